// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART transmit path.
//   uart_fifo_trig_e     : transmit interrupt threshold select (trig_lvl_i)
//   UART_FIFO_DEPTH_DEF  : default number of transmit FIFO entries
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    TRIG_1_8 = 2'd0,
    TRIG_1_4 = 2'd1,
    TRIG_1_2 = 2'd2,
    TRIG_3_4 = 2'd3
  } uart_fifo_trig_e;

  localparam int UART_FIFO_DEPTH_DEF = 16;

endpackage

// File: rtl/uart_fifo_ram.sv
// ---------------------------------------------------------------------------
// uart_fifo_ram
// DEPTH x 8 register array: one synchronous write port, one asynchronous
// read port. Contents are not reset.
//   clk_i    : clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address
//   rdata_o  : read data (combinational from raddr_i)
// ---------------------------------------------------------------------------
module uart_fifo_ram #(
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// Transmit byte buffer between the THR write path and uart_tx. Holds up to
// DEPTH bytes (one byte when lcr_fen_i is low), presents the head byte on the
// rdy/ack handshake, reports level/full/empty, flags pushes dropped while
// full and raises a level-based transmit interrupt.
//
// Build option: define UART_TX_FIFO_TRIG_EN to make tx_irq_o use the
// programmable threshold selected by trig_lvl_i; otherwise trig_lvl_i is
// ignored and tx_irq_o equals empty_o.
//
// Ports:
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   lcr_fen_i             : FIFO enable (0 = single-entry holding register)
//   fifo_clr_i            : synchronous flush
//   wr_data_i, wr_en_i    : push byte / strobe
//   uart_tx_data_o        : head byte
//   uart_tx_data_rdy_o    : head byte valid
//   uart_tx_data_ack_i    : pop strobe from uart_tx
//   trig_lvl_i            : interrupt threshold select
//   level_o, full_o, empty_o : occupancy status
//   ovf_o, ovf_clr_i      : sticky overflow flag and its clear
//   tx_irq_o              : transmit interrupt
// ---------------------------------------------------------------------------
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_FIFO_DEPTH_DEF,
  localparam int LW   = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          lcr_fen_i,
  input  logic          fifo_clr_i,
  input  logic [7:0]    wr_data_i,
  input  logic          wr_en_i,
  output logic [7:0]    uart_tx_data_o,
  output logic          uart_tx_data_rdy_o,
  input  logic          uart_tx_data_ack_i,
  input  logic [1:0]    trig_lvl_i,
  output logic [LW-1:0] level_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          ovf_o,
  input  logic          ovf_clr_i,
  output logic          tx_irq_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;
  // Registered copy of lcr_fen_i: capacity is taken from it so no status
  // output depends combinationally on the input, and a mismatch with the
  // live input marks a mode change that must flush.
  logic          fen_q;

  logic [LW-1:0] cap;
  logic          full, empty;
  logic          push, pop, flush;

  assign cap   = fen_q ? LW'(DEPTH) : LW'(1);
  assign full  = (level_q == cap);
  assign empty = (level_q == '0);

  assign pop   = uart_tx_data_ack_i && !empty;
  // A push while full still fits when the head leaves in the same cycle.
  assign push  = wr_en_i && (!full || pop);
  assign flush = fifo_clr_i || (lcr_fen_i != fen_q);

  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    level_d = level_q;
    if (flush) begin
      rptr_d  = '0;
      wptr_d  = '0;
      level_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + AW'(1);
      if (pop)  rptr_d = rptr_q + AW'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Set has priority over clear. A push discarded by a flush is not counted
  // as an overflow.
  always_comb begin
    ovf_d = ovf_q;
    if (wr_en_i && full && !pop && !flush) begin
      ovf_d = 1'b1;
    end else if (ovf_clr_i) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      fen_q   <= 1'b0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      fen_q   <= lcr_fen_i;
    end
  end

  uart_fifo_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (push && !flush),
    .waddr_i (wptr_q),
    .wdata_i (wr_data_i),
    .raddr_i (rptr_q),
    .rdata_o (uart_tx_data_o)
  );

  assign uart_tx_data_rdy_o = !empty;
  assign level_o            = level_q;
  assign full_o             = full;
  assign empty_o            = empty;
  assign ovf_o              = ovf_q;

`ifdef UART_TX_FIFO_TRIG_EN
  // Threshold select is registered so tx_irq_o is decoded purely from state.
  uart_fifo_trig_e trig_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      trig_q <= TRIG_1_8;
    end else begin
      trig_q <= uart_fifo_trig_e'(trig_lvl_i);
    end
  end

  function automatic logic [LW-1:0] trig_thresh(input uart_fifo_trig_e t);
    case (t)
      TRIG_1_8: trig_thresh = LW'(DEPTH / 8);
      TRIG_1_4: trig_thresh = LW'(DEPTH / 4);
      TRIG_1_2: trig_thresh = LW'(DEPTH / 2);
      default:  trig_thresh = LW'((3 * DEPTH) / 4);
    endcase
  endfunction

  assign tx_irq_o = fen_q ? (level_q <= trig_thresh(trig_q)) : empty;
`else
  logic unused_trig;
  assign unused_trig = ^trig_lvl_i;
  assign tx_irq_o    = empty;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo
// Self-checking bench for uart_tx_fifo (DEPTH = 16). Accepted bytes are
// pushed into a scoreboard queue and compared when the DUT pops them; a small
// model tracks level, overflow, mode and threshold for the status outputs.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int LW    = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          fen;
  logic          fclr;
  logic [7:0]    wd;
  logic          wr;
  logic [7:0]    dout;
  logic          rdy;
  logic          ack;
  logic [1:0]    trig;
  logic [LW-1:0] level;
  logic          full;
  logic          empty;
  logic          ovf;
  logic          oclr;
  logic          irq;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .DEPTH (DEPTH)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .lcr_fen_i          (fen),
    .fifo_clr_i         (fclr),
    .wr_data_i          (wd),
    .wr_en_i            (wr),
    .uart_tx_data_o     (dout),
    .uart_tx_data_rdy_o (rdy),
    .uart_tx_data_ack_i (ack),
    .trig_lvl_i         (trig),
    .level_o            (level),
    .full_o             (full),
    .empty_o            (empty),
    .ovf_o              (ovf),
    .ovf_clr_i          (oclr),
    .tx_irq_o           (irq)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] sb [$];
  int         m_level;
  logic       m_ovf;
  logic       m_fenq;
  logic [1:0] m_trigq;
  logic [7:0] last_pop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_irq();
`ifdef UART_TX_FIFO_TRIG_EN
    int thr;
    if (!m_fenq) thr = 0;
    else begin
      case (m_trigq)
        2'd0:    thr = DEPTH / 8;
        2'd1:    thr = DEPTH / 4;
        2'd2:    thr = DEPTH / 2;
        default: thr = (3 * DEPTH) / 4;
      endcase
    end
    return (m_level <= thr);
`else
    return (m_level == 0);
`endif
  endfunction

  task automatic model_reset();
    sb.delete();
    m_level = 0;
    m_ovf   = 1'b0;
    m_fenq  = 1'b0;
    m_trigq = 2'd0;
  endtask

  task automatic check_status(input string tag);
    int cap;
    cap = m_fenq ? DEPTH : 1;
    chk({tag, ".level"}, 32'(level), 32'(m_level));
    chk({tag, ".empty"}, 32'(empty), 32'(m_level == 0));
    chk({tag, ".rdy"},   32'(rdy),   32'(m_level != 0));
    chk({tag, ".full"},  32'(full),  32'(m_level == cap));
    chk({tag, ".ovf"},   32'(ovf),   32'(m_ovf));
    chk({tag, ".irq"},   32'(irq),   32'(exp_irq()));
    if (m_level != 0 && sb.size() != 0) chk({tag, ".head"}, 32'(dout), 32'(sb[0]));
  endtask

  // One clock cycle with the given strobes; fen and trig are taken as set.
  task automatic cyc(input logic wr_v, input logic [7:0] d, input logic ack_v,
                     input logic clr_v, input logic oclr_v);
    int   cap;
    logic m_full, pop, push, flush;
    logic [7:0] e;
    wr = wr_v; wd = d; ack = ack_v; fclr = clr_v; oclr = oclr_v;
    cap    = m_fenq ? DEPTH : 1;
    m_full = (m_level == cap);
    pop    = ack_v && (m_level != 0);
    push   = wr_v && (!m_full || pop);
    flush  = clr_v || (fen !== m_fenq);
    if (!flush && pop) begin
      e = sb.pop_front();
      chk("pop_data", 32'(dout), 32'(e));
      last_pop = e;
    end
    @(posedge clk);
    #1;
    if (flush) begin
      sb.delete();
      m_level = 0;
    end else begin
      if (push) sb.push_back(d);
      m_level = m_level + int'(push) - int'(pop);
    end
    if (wr_v && m_full && !pop && !flush) m_ovf = 1'b1;
    else if (oclr_v)                      m_ovf = 1'b0;
    m_fenq  = fen;
    m_trigq = trig;
    wr = 1'b0; ack = 1'b0; fclr = 1'b0; oclr = 1'b0;
    check_status("cyc");
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ".level"}, 32'(level), 32'd0);
    chk({tag, ".empty"}, 32'(empty), 32'd1);
    chk({tag, ".full"},  32'(full),  32'd0);
    chk({tag, ".rdy"},   32'(rdy),   32'd0);
    chk({tag, ".ovf"},   32'(ovf),   32'd0);
    chk({tag, ".irq"},   32'(irq),   32'd1);
  endtask

  initial begin
    rst = 1'b1; fen = 1'b1; fclr = 1'b0; wd = 8'h00; wr = 1'b0;
    ack = 1'b0; trig = 2'd0; oclr = 1'b0; last_pop = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;
    cyc(0, 8'h00, 0, 0, 0);
    cyc(0, 8'h00, 0, 0, 0);

    // Ordering
    cyc(1, 8'h11, 0, 0, 0);
    cyc(1, 8'h22, 0, 0, 0);
    cyc(1, 8'h33, 0, 0, 0);
    chk("ord.level", 32'(level), 32'd3);
    chk("ord.rdy",   32'(rdy),   32'd1);
    chk("ord.data",  32'(dout),  32'h11);
    cyc(0, 8'h00, 1, 0, 0);
    chk("ord.data2",  32'(dout),  32'h22);
    chk("ord.level2", 32'(level), 32'd2);
    repeat (2) cyc(0, 8'h00, 1, 0, 0);
    cyc(0, 8'h00, 1, 0, 0);  // ack while empty is ignored

    // Fill and overflow
    for (int i = 0; i < 16; i++) cyc(1, 8'(i), 0, 0, 0);
    chk("fill.full", 32'(full), 32'd1);
    cyc(1, 8'hAA, 0, 0, 0);
    chk("ovf.set",   32'(ovf),   32'd1);
    chk("ovf.level", 32'(level), 32'd16);
    for (int i = 0; i < 16; i++) cyc(0, 8'h00, 1, 0, 0);
    chk("drain.last", 32'(last_pop), 32'h0F);
    chk("drain.empty", 32'(empty), 32'd1);
    cyc(0, 8'h00, 0, 0, 1);
    chk("ovf.clr", 32'(ovf), 32'd0);

    // Simultaneous push/pop at full
    for (int i = 0; i < 16; i++) cyc(1, 8'h20 + 8'(i), 0, 0, 0);
    cyc(1, 8'h55, 1, 0, 0);
    chk("pp.level", 32'(level), 32'd16);
    chk("pp.ovf",   32'(ovf),   32'd0);
    for (int i = 0; i < 16; i++) cyc(0, 8'h00, 1, 0, 0);
    chk("pp.last", 32'(last_pop), 32'h55);

    // FIFO disabled: single holding register
    fen = 1'b0;
    cyc(0, 8'h00, 0, 0, 0);
    cyc(1, 8'h01, 0, 0, 0);
    cyc(1, 8'h02, 0, 0, 0);
    chk("dis.ovf",   32'(ovf),   32'd1);
    chk("dis.full",  32'(full),  32'd1);
    chk("dis.level", 32'(level), 32'd1);
    chk("dis.data",  32'(dout),  32'h01);
    fen = 1'b1;
    cyc(0, 8'h00, 0, 0, 0);
    chk("fen.flush", 32'(level), 32'd0);

    // Threshold
    trig = 2'd2;
    cyc(0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 9; i++) cyc(1, 8'h40 + 8'(i), 0, 0, 0);
    chk("thr.irq9", 32'(irq), 32'd0);
    cyc(0, 8'h00, 1, 0, 0);
    chk("thr.level8", 32'(level), 32'd8);
`ifdef UART_TX_FIFO_TRIG_EN
    chk("thr.irq8", 32'(irq), 32'd1);
`else
    chk("thr.irq8", 32'(irq), 32'd0);
`endif
    for (int i = 0; i < 8; i++) cyc(0, 8'h00, 1, 0, 0);
    chk("thr.irq0", 32'(irq), 32'd1);

    // Flush with push and ack in the same cycle
    for (int i = 0; i < 5; i++) cyc(1, 8'h60 + 8'(i), 0, 0, 0);
    chk("fl.level5", 32'(level), 32'd5);
    cyc(1, 8'h99, 1, 1, 0);
    chk("fl.level", 32'(level), 32'd0);
    chk("fl.empty", 32'(empty), 32'd1);
    chk("fl.ovf",   32'(ovf),   32'd1);

    // Reset mid-operation
    for (int i = 0; i < 7; i++) cyc(1, 8'h70 + 8'(i), 0, 0, 0);
    chk("rst.level7", 32'(level), 32'd7);
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("rst.async");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_status("rst.hold");
    cyc(0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 8'h80 + 8'(i), 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 8'h00, 1, 0, 0);
    chk("post.last", 32'(last_pop), 32'h82);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Transmit-side byte buffer of the UART, sitting between the register interface (THR writes) and `uart_tx`. It stores up to DEPTH bytes, presents the head byte on the `uart_tx` ready/ack handshake, and pops the head when the serializer acknowledges the start bit. It also reports level and full/empty status, flags writes that arrive while it is full, and raises a programmable-threshold transmit interrupt. When `lcr_fen_i` is low it behaves as a single-entry holding register.

## Interface
- DEPTH, 16: number of FIFO entries; power of two, at least 8.
- LW, $clog2(DEPTH)+1: width of `level_o`; derived, not overridden.

- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- lcr_fen_i  in  1  FIFO enable; 0 limits capacity to 1 entry
- fifo_clr_i  in  1  synchronous flush
- wr_data_i  in  8  byte to push
- wr_en_i  in  1  push strobe, one byte per cycle
- uart_tx_data_o  out  8  head byte
- uart_tx_data_rdy_o  out  1  head byte valid
- uart_tx_data_ack_i  in  1  pop strobe from `uart_tx`
- trig_lvl_i  in  2  interrupt threshold select
- level_o  out  LW  current occupancy
- full_o  out  1  occupancy equals capacity
- empty_o  out  1  occupancy is 0
- ovf_o  out  1  sticky overflow flag
- ovf_clr_i  in  1  clears `ovf_o`
- tx_irq_o  out  1  level-based transmit interrupt

## Operation
- Capacity: DEPTH when `lcr_fen_i`=1, otherwise 1.
- Storage: circular buffer with read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus an LW-bit occupancy counter.
- Push: `wr_en_i` && !`full_o` writes `wr_data_i` at the write pointer and increments the write pointer.
- Push while full:
  - The byte is dropped and `ovf_o` is set.
  - Exception: if `uart_tx_data_ack_i` is also valid in that cycle, the push is accepted and the level is unchanged.
- Pop: `uart_tx_data_ack_i` && `uart_tx_data_rdy_o` increments the read pointer. An ack while empty is ignored and changes no state.
- Simultaneous push and pop: level unchanged, both pointers advance.
- `uart_tx_data_rdy_o` = !`empty_o`.
- `uart_tx_data_o` = memory at the read pointer, read asynchronously. It must stay stable while rdy is high and no ack is given.
- Flush: `fifo_clr_i`, or any change of `lcr_fen_i` (detected with a registered copy), zeroes both pointers and the level. Flush wins over a push or pop in the same cycle. `ovf_o` is not affected.
- `ovf_o`: set on a dropped push, cleared by `ovf_clr_i`. If both happen in the same cycle, set wins.
- `tx_irq_o`: asserted when level ≤ threshold.
  - Thresholds for `trig_lvl_i` 0/1/2/3: DEPTH/8, DEPTH/4, DEPTH/2, 3·DEPTH/4.
  - When `lcr_fen_i`=0 the threshold is 0.
- Arithmetic: level is LW bits and never exceeds capacity; the design relies on there being no wrap past DEPTH.

## Timing
- Reset values:
  - `level_o`=0, `empty_o`=1, `full_o`=0, `uart_tx_data_rdy_o`=0, `ovf_o`=0, `tx_irq_o`=1.
  - `uart_tx_data_o` = memory contents; this is don't-care while rdy is low.
  - Memory itself is not reset.
- Push-to-ready latency: push in cycle N gives `uart_tx_data_rdy_o`=1 in cycle N+1.
- Pop takes effect at the next edge. With ack in cycle N, the next head byte appears in cycle N+1.
- All status outputs (`level_o`, `full_o`, `empty_o`, `ovf_o`, `tx_irq_o`) are registered or decoded from registered state; none depends combinationally on inputs.
- Reset mid-operation: reset asserted at any time discards all contents immediately, and outputs take their reset values asynchronously.
- Pop rate: `uart_tx` acks at most once per character, so pops are sparse. The FIFO still accepts back-to-back ack on consecutive cycles.

## Configuration
- Macro `UART_TX_FIFO_TRIG_EN`.
- Defined: `tx_irq_o` uses the programmable threshold from `trig_lvl_i` as described above.
- Undefined: `trig_lvl_i` is ignored, the comparator logic is not built, and `tx_irq_o` = `empty_o`.

## Structure
- Package `uart_pkg` holds:
  - `uart_fifo_trig_e` with values TRIG_1_8, TRIG_1_4, TRIG_1_2, TRIG_3_4;
  - constant UART_FIFO_DEPTH_DEF = 16.
- Sub-module `uart_fifo_ram`: DEPTH×8 register array with one synchronous write port and one asynchronous read port.
- Pointers, level, flush, overflow and interrupt logic live in `uart_tx_fifo`.

## Test plan
- Ordering: FIFO enabled, push 0x11,0x22,0x33 with no ack → level 3, rdy=1, data 0x11. Ack once → data 0x22, level 2.
- Fill and overflow: push 16 bytes 0x00..0x0F → `full_o`=1. Push 0xAA → dropped, `ovf_o`=1, level 16. Pop all → read order 0x00..0x0F with no 0xAA. `ovf_clr_i` → `ovf_o`=0.
- Simultaneous push/pop at full: push 0x55 with ack in the same cycle → level stays 16, 0x55 is read last after draining.
- FIFO disabled: `lcr_fen_i`=0, push 0x01 then 0x02 → second push dropped, `ovf_o`=1, `full_o`=1 at level 1. Toggle `lcr_fen_i` to 1 → flushed, level 0.
- Threshold: `trig_lvl_i`=2, DEPTH=16, load 9 bytes → `tx_irq_o`=0. Pop 1 → level 8, `tx_irq_o`=1. With the macro undefined, `tx_irq_o` stays 0 until level 0.
- Flush and reset: `fifo_clr_i` together with push and ack at level 5 → level 0, `empty_o`=1, `ovf_o` unchanged. `rst_i` pulse at level 7 → all reset values the same cycle.
